// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register with redirect/stall priority and the IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic        if_id_valid
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
   localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic        kill_ifid;
   logic        hold;
   logic        capture;
   logic [31:0] seq_pc;

   always_comb begin
      redirect  = branch_taken | jump;
      kill_ifid = redirect | flush;
      hold      = stall & ~redirect;
      // A fetch is only committed to decode when nothing redirects, flushes or stalls.
      capture   = ~kill_ifid & ~stall;
      seq_pc    = pc_q + 32'd4;
   end

   always_comb begin
      pc_d = seq_pc;
      if (branch_taken) begin
         pc_d = branch_target & WORD_MASK;
      end else if (jump) begin
         pc_d = jump_target & WORD_MASK;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   // pc4 is deliberately left alone on a kill so decode keeps a stable link value.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (kill_ifid) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (capture) begin
         instr_d = imem_instr;
         pc4_d   = seq_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (capture) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (hold) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_cnt_q <= 32'h0000_0000;
         stall_cnt_q <= 32'h0000_0000;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   logic unused_hold;
   assign unused_hold = hold;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset (bits [1:0] ignored, treated as 0).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port stall  input  1  hazard hold request from decode.
REQ-005 SHALL have port flush  input  1  clears the IF/ID register.
REQ-006 SHALL have port branch_taken  input  1  conditional branch redirect.
REQ-007 SHALL have port branch_target  input  32  branch destination byte address.
REQ-008 SHALL have port jump  input  1  unconditional jump redirect.
REQ-009 SHALL have port jump_target  input  32  jump destination byte address.
REQ-010 SHALL have port imem_addr  output  32  current PC, driven to instruction memory Address.
REQ-011 SHALL have port imem_instr  input  32  combinational instruction word returned for imem_addr.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction for decode.
REQ-013 SHALL have port if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-014 SHALL have port if_id_valid  output  1  if_id_instr holds a real instruction.

Function
REQ-015 SHALL drive imem_addr directly from the PC register, with PC[1:0] always 0.
REQ-016 SHALL apply next-PC priority per cycle: reset > branch_taken > jump > stall > sequential.
REQ-017 SHALL load PC with {branch_target[31:2],2'b00} when branch_taken=1, regardless of jump or stall.
REQ-018 SHALL load PC with {jump_target[31:2],2'b00} when jump=1 and branch_taken=0, regardless of stall.
REQ-019 SHALL hold PC when stall=1 and no redirect is asserted.
REQ-020 SHALL otherwise load PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-021 SHALL, on sequential advance, capture imem_instr into if_id_instr, PC+4 into if_id_pc4, and set if_id_valid=1; latency from PC update to if_id_instr is exactly one cycle.
REQ-022 SHALL, on branch_taken, jump or flush, clear if_id_instr to 32'h00000000 (nop), set if_id_valid=0, and leave if_id_pc4 unchanged.
REQ-023 SHALL, on stall without redirect or flush, hold if_id_instr, if_id_pc4 and if_id_valid unchanged.
REQ-024 SHALL give flush priority over stall for the IF/ID register; flush alone does not change PC.
REQ-025 SHALL issue no combinational path from any input to imem_addr or IF/ID outputs.

Reset
REQ-026 SHALL, when reset_n=0 at a rising edge, set PC={RESET_PC[31:2],2'b00}, if_id_instr=0, if_id_pc4=0, if_id_valid=0, overriding all other inputs.
REQ-027 SHALL, on reset asserted mid-stream (including during stall or redirect), discard all in-flight state; the first instruction after release is the one at RESET_PC.
REQ-028 SHALL fetch RESET_PC in the first cycle with reset_n=1, presenting it on if_id_instr the following cycle.

Configuration
REQ-029 SHALL, when macro FETCH_PERF_CNT_EN is defined, add outputs fetch_count (32) and stall_count (32): fetch_count increments on each REQ-021 capture, stall_count on each cycle with stall=1 and no redirect; both reset to 0 and wrap at 2^32.
REQ-030 SHALL, when FETCH_PERF_CNT_EN is undefined, omit both ports and their counters entirely.

Verification
REQ-031 SHALL cover: reset with RESET_PC=0, release, 4 cycles -> imem_addr 0,4,8,C; if_id_pc4 4,8,C with if_id_valid=1 from cycle 2.
REQ-032 SHALL cover: stall=1 for 3 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged; after release PC=C next.
REQ-033 SHALL cover: branch_taken=1, branch_target=32'h18, jump=1, jump_target=32'h40, stall=1 in same cycle -> PC=18 next, if_id_valid=0, if_id_instr=0.
REQ-034 SHALL cover: jump_target=32'h2D (unaligned) -> PC=2C.
REQ-035 SHALL cover: PC forced to FFFFFFFC via jump, sequential advance -> PC=0, if_id_pc4=0.
REQ-036 SHALL cover: reset_n=0 asserted during stall with PC=20 -> next cycle PC=RESET_PC, if_id_valid=0; with FETCH_PERF_CNT_EN, both counters read 0.
